// File: rtl/lfsr_rand_arbiter.sv
// Round-robin front end sharing one Fibonacci LFSR: a grant runs SHIFTS shift cycles, then the
// word is held (LFSR frozen) on a valid/ready response until the consumer takes it.
module lfsr_rand_arbiter #(
  parameter int              WIDTH  = 16,
  parameter int              NREQ   = 4,
  parameter int              SHIFTS = 16,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  input  logic                    reseed_valid,
  input  logic [WIDTH-1:0]        reseed_value,
  output logic                    reseed_ack,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    lfsr_load,
  output logic                    lfsr_shift_en,
  output logic [WIDTH-1:0]        lfsr_in,
  output logic                    lfsr_din,
  input  logic [WIDTH-1:0]        lfsr_out
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(SHIFTS + 1);

  typedef enum logic [1:0] {INIT, IDLE, RUN, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   idx;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(rr_q) + i) % NREQ);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= INIT;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      seed_q  <= SEED;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    gnt_d   = '0;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        // A stuck-at-zero LFSR can never recover on its own, so it outranks everything.
        if (lfsr_out == '0) begin
          state_d = INIT;
          seed_d  = SEED;
        end else if (reseed_valid) begin
          state_d = INIT;
          seed_d  = (reseed_value == '0) ? SEED : reseed_value;
        end else if (win_found) begin
          state_d        = RUN;
          owner_d        = win_idx;
          cnt_d          = CW'(SHIFTS - 1);
          rr_d           = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
          gnt_d[win_idx] = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // While reset is asserted every output is forced quiet and the LFSR sees the default seed.
  always_comb begin
    gnt           = '0;
    reseed_ack    = 1'b0;
    rsp_valid     = 1'b0;
    rsp_id        = '0;
    rsp_data      = '0;
    lfsr_load     = 1'b0;
    lfsr_shift_en = 1'b0;
    lfsr_in       = SEED;
    if (rst_b) begin
      lfsr_in = seed_q;
      gnt     = gnt_q;
      case (state_q)
        INIT: lfsr_load = 1'b1;
        IDLE: reseed_ack = reseed_valid && (lfsr_out != '0);
        RUN:  lfsr_shift_en = 1'b1;
        RESP: begin
          rsp_valid = 1'b1;
          rsp_id    = owner_q;
          rsp_data  = lfsr_out;
        end
        default: lfsr_load = 1'b0;
      endcase
    end
  end

  assign lfsr_din = 1'b0;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Bench for lfsr_rand_arbiter with a behavioural 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
// attached, and a reference model of grant order and expected random words.
module tb_lfsr_rand_arbiter;
  localparam int          NREQ   = 4;
  localparam int          SHIFTS = 16;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic        reseed_valid = 1'b0;
  logic [15:0] reseed_value = '0;
  logic        reseed_ack;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        lfsr_load;
  logic        lfsr_shift_en;
  logic [15:0] lfsr_in;
  logic        lfsr_din;
  logic [15:0] lfsr_out;

  int errors = 0;
  int checks = 0;
  int rr_m = 0;
  logic [15:0] exp_word = SEED;

  lfsr_rand_arbiter #(.WIDTH(16), .NREQ(NREQ), .SHIFTS(SHIFTS), .SEED(SEED)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .gnt(gnt),
    .reseed_valid(reseed_valid), .reseed_value(reseed_value), .reseed_ack(reseed_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .lfsr_load(lfsr_load), .lfsr_shift_en(lfsr_shift_en), .lfsr_in(lfsr_in),
    .lfsr_din(lfsr_din), .lfsr_out(lfsr_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic d);
    return {s[0] ^ s[2] ^ s[3] ^ s[5] ^ d, s[15:1]};
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = lfsr_step(r, 1'b0);
    return r;
  endfunction

  // The LFSR datapath the controller drives.
  logic [15:0] lfsr_q = '0;
  assign lfsr_out = lfsr_q;
  always @(posedge clk) begin
    if (lfsr_load) lfsr_q <= lfsr_in;
    else if (lfsr_shift_en) lfsr_q <= lfsr_step(lfsr_q, lfsr_din);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_b = 1'b0; req = '0; reseed_valid = 1'b0; reseed_value = '0; rsp_ready = 1'b0;
    tick;
    tick;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_load", 32'(lfsr_load), 32'h0);
    chk("rst_shift", 32'(lfsr_shift_en), 32'h0);
    chk("rst_lfsr_in", 32'(lfsr_in), 32'(SEED));
    rst_b = 1'b1;
    #1;
    chk("init_load", 32'(lfsr_load), 32'h1);
    chk("init_lfsr_in", 32'(lfsr_in), 32'(SEED));
    chk("init_gnt", 32'(gnt), 32'h0);
    chk("init_rsp_valid", 32'(rsp_valid), 32'h0);
    tick;
    chk("idle_load", 32'(lfsr_load), 32'h0);
    chk("idle_word", 32'(lfsr_out), 32'(SEED));
    chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
    rr_m = 0;
    exp_word = SEED;
  endtask

  // Entered in an IDLE cycle; one full request/grant/shift/response transaction.
  task automatic serve(input logic [3:0] mask, input int hold, output int id_seen);
    int w;
    int n;
    int k;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      k = (rr_m + i) % NREQ;
      if (w < 0 && ((mask >> k) & 4'd1) != 4'd0) w = k;
    end
    req = mask;
    tick;
    chk("gnt_onehot", 32'(gnt), 32'(4'd1 << w));
    rr_m = (w + 1) % NREQ;
    n = 0;
    while (lfsr_shift_en === 1'b1 && n < 100) begin
      n++;
      tick;
      if (n == 1) chk("gnt_one_cycle", 32'(gnt), 32'h0);
    end
    chk("shift_cycles", 32'(n), 32'(SHIFTS));
    exp_word = lfsr_adv(exp_word, SHIFTS);
    chk("rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rsp_id", 32'(rsp_id), 32'(w));
    chk("rsp_data", 32'(rsp_data), 32'(exp_word));
    id_seen = int'(rsp_id);
    for (int c = 0; c < hold; c++) begin
      tick;
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_id", 32'(rsp_id), 32'(w));
      chk("bp_data", 32'(rsp_data), 32'(exp_word));
      chk("bp_shift", 32'(lfsr_shift_en), 32'h0);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("post_hs_valid", 32'(rsp_valid), 32'h0);
    chk("post_hs_zero", 32'({rsp_id, rsp_data}), 32'h0);
  endtask

  // Entered in an IDLE cycle; reseed raised together with a pending request mask.
  task automatic reseed(input logic [15:0] v, input logic [3:0] mask);
    logic [15:0] want;
    want = (v == 16'h0) ? SEED : v;
    reseed_valid = 1'b1; reseed_value = v; req = mask;
    #1;
    chk("reseed_ack", 32'(reseed_ack), 32'h1);
    tick;
    reseed_valid = 1'b0;
    chk("reseed_ack_pulse", 32'(reseed_ack), 32'h0);
    chk("reseed_load", 32'(lfsr_load), 32'h1);
    chk("reseed_lfsr_in", 32'(lfsr_in), 32'(want));
    chk("reseed_no_gnt", 32'(gnt), 32'h0);
    tick;
    exp_word = want;
    chk("reseed_word", 32'(lfsr_out), 32'(exp_word));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int id;
    int seen;
    logic [3:0] m;

    do_reset;
    serve(4'b0100, 0, id);

    do_reset;
    for (int i = 0; i < 5; i++) begin
      serve(4'b1111, 0, id);
      chk("rr_order", 32'(id), 32'(i % NREQ));
    end

    serve(4'b0001, 10, id);

    reseed(16'h1234, 4'b0010);
    serve(4'b0010, 0, id);
    chk("pending_after_reseed", 32'(id), 32'h1);
    reseed(16'h0000, 4'b0000);

    for (int i = 0; i < 8; i++) begin
      m = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) reseed(16'($urandom_range(0, 65535)), m);
      serve(m, int'($urandom_range(0, 3)), id);
    end

    req = 4'b1000;
    tick;
    req = 4'b0000;
    repeat (8) tick;
    chk("abort_running", 32'(lfsr_shift_en), 32'h1);
    rst_b = 1'b0;
    tick;
    rst_b = 1'b1;
    #1;
    chk("abort_gnt", 32'(gnt), 32'h0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("abort_shift", 32'(lfsr_shift_en), 32'h0);
    chk("abort_load", 32'(lfsr_load), 32'h1);
    chk("abort_lfsr_in", 32'(lfsr_in), 32'(SEED));
    tick;
    chk("abort_word", 32'(lfsr_out), 32'(SEED));
    rr_m = 0;
    exp_word = SEED;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid !== 1'b0) seen++;
      tick;
    end
    chk("abort_no_rsp", 32'(seen), 32'h0);
    serve(4'b1111, 1, id);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
